fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the RV32I control decoder. Holds the PC,
//  fetches one instruction per step over a ready-handshake imem port, presents instr/op/funct3/
//  func7_5 to control, and computes the next PC from control's PCsrc (PC+4, PC+ImmExt, or jalr
//  target). Execution is single-cycle; downstream may stall to hold the current instruction.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset (must be 4-byte aligned)
//  NOP_INSTR 32'h0000_0013  instr value presented when no valid instruction (addi x0,x0,0)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  PCsrc        in   1   from control: 1 = take redirect target
//  jalr_sel     in   1   1 = redirect target is {ALUResult[31:1],1'b0}; 0 = PC+ImmExt
//  ImmExt       in   32  sign-extended immediate (branch/jal offset)
//  ALUResult    in   32  jalr target before LSB clear
//  stall        in   1   1 = hold current instruction, do not advance
//  imem_req     out  1   fetch request; imem_addr valid while high
//  imem_addr    out  32  fetch address (= PC)
//  imem_ready   in   1   imem_rdata valid this cycle, request completes
//  imem_rdata   in   32  fetched instruction word
//  instr        out  32  current instruction to decode
//  instr_valid  out  1   instr is live; downstream qualifies RegWrite/MemWrite with it
//  op           out  7   instr[6:0]
//  funct3       out  3   instr[14:12]
//  func7_5      out  1   instr[30]
//  PC           out  32  address of instr
//  PCPlus4      out  32  PC+4 (jal/jalr link value)
//  instret      out  32  retired-instruction counter
//  misalign_err out  1   sticky: redirect target had bits[1:0] != 0
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, PC=RESET_PC, instr=NOP_INSTR, instr_valid=0,
//   imem_req=0, instret=0, misalign_err=0. Reset mid-fetch discards the outstanding request.
//  FSM states IDLE, FETCH, EXEC, ERR:
//   IDLE : one cycle after reset release -> FETCH.
//   FETCH: imem_req=1, imem_addr=PC. On imem_ready: instr<=imem_rdata, -> EXEC.
//          imem_ready while imem_req=0 is ignored.
//   EXEC : instr_valid=1. If stall=1: hold everything. If stall=0 (retire): instret<=instret+1
//          (wraps 0xFFFF_FFFF->0); next=PCsrc?(jalr_sel?{ALUResult[31:1],0}:PC+ImmExt):PC+4;
//          if next[1:0]!=0 -> misalign_err<=1, PC unchanged, -> ERR; else PC<=next, -> FETCH.
//   ERR  : terminal until reset; instr_valid=0, imem_req=0, instr=NOP_INSTR.
//  instr_valid=0 in IDLE/FETCH/ERR; instr held at last value in FETCH but must not be qualified.
//  Fetch latency: min 1 cycle FETCH + 1 cycle EXEC per instruction (2-cycle CPI at zero wait).
//  All PC arithmetic is 32-bit modulo; PC+4 at 0xFFFF_FFFC wraps to 0, no error.
//  PCsrc/jalr_sel/ImmExt/ALUResult sampled only on the retiring EXEC edge; ignored otherwise.
//  op/funct3/func7_5 are pure slices of instr; PCPlus4 is combinational from PC.
// TESTING
//  1 Reset release, imem_ready=1 always, rdata=NOP -> imem_addr 0,4,8 on successive FETCH;
//    instret=3 after 3 EXEC cycles.
//  2 PC=0x10 in EXEC, PCsrc=1, jalr_sel=0, ImmExt=0xFFFF_FFF8 -> next imem_addr=0x08.
//  3 EXEC, PCsrc=1, jalr_sel=1, ALUResult=0x0000_0105 -> PC=0x104, no error.
//  4 imem_ready low 3 cycles in FETCH -> imem_req held, instr_valid=0 for those cycles,
//    instr_valid=1 the cycle after ready; stall=1 for 2 EXEC cycles -> PC/instr/instret unchanged.
//  5 EXEC, PCsrc=1, jalr_sel=0, PC=0x20, ImmExt=0x6 -> misalign_err=1, state ERR, imem_req=0
//    forever, PC=0x20; rst_n low clears.
//  6 rst_n pulsed low mid-FETCH (async, between edges) -> outputs at reset values immediately;
//    first request after release at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a ready-handshake imem port, feeds the decoder.
// Latency: 1 FETCH cycle (plus imem wait cycles) + 1 EXEC cycle per instruction; CPI 2 at zero wait.
// Backpressure: imem_ready low holds the request; stall high holds the current instruction in EXEC.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCsrc,
    input  logic        jalr_sel,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        func7_5,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] instret,
    output logic        misalign_err
);

    // IDLE is a single settling cycle after reset; ERR is terminal until reset.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instret_q;
    logic        req_q;
    logic        valid_q;
    logic        err_q;

    logic [31:0] pc_plus4;
    logic [31:0] branch_tgt;
    logic [31:0] jalr_tgt;
    logic [31:0] next_pc_d;
    logic        next_misaligned;
    logic        retire;

    // Candidate next PC; only consumed on the retiring EXEC edge, so the
    // control inputs are effectively ignored in every other cycle.
    always_comb begin
        pc_plus4        = pc_q + 32'd4;
        branch_tgt      = pc_q + ImmExt;
        // Masking (rather than slicing) keeps every ALUResult bit in the cone.
        jalr_tgt        = ALUResult & ~32'h0000_0001;
        next_pc_d       = pc_plus4;
        if (PCsrc) begin
            next_pc_d = jalr_sel ? jalr_tgt : branch_tgt;
        end
        next_misaligned = (next_pc_d[1:0] != 2'b00);
        retire          = (state_q == S_EXEC) && !stall;
    end

    // Sequencer: state, PC, instruction latch, retire counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            instret_q <= 32'd0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
                S_FETCH: begin
                    // instr_q keeps its old value while waiting; valid_q is low so
                    // downstream never qualifies it.
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        state_q <= S_EXEC;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (retire) begin
                        instret_q <= instret_q + 32'd1;
                        valid_q   <= 1'b0;
                        if (next_misaligned) begin
                            // PC stays at the faulting instruction for post-mortem.
                            err_q   <= 1'b1;
                            instr_q <= NOP_INSTR;
                            state_q <= S_ERR;
                        end else begin
                            pc_q    <= next_pc_d;
                            req_q   <= 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                default: begin
                    // ERR: everything frozen, no further requests.
                    state_q <= S_ERR;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    instr_q <= NOP_INSTR;
                end
            endcase
        end
    end

    // Output mapping: decode fields are plain slices of the held instruction.
    always_comb begin
        imem_req     = req_q;
        imem_addr    = pc_q;
        instr        = instr_q;
        instr_valid  = valid_q;
        op           = instr_q[6:0];
        funct3       = instr_q[14:12];
        func7_5      = instr_q[30];
        PC           = pc_q;
        PCPlus4      = pc_plus4;
        instret      = instret_q;
        misalign_err = err_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized imem wait/stall/redirect traffic.
// Every cycle the DUT outputs are compared with a transaction-level model of the fetch/execute loop.
// Inputs are driven just after the falling edge; outputs are sampled on the falling edge.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        PCsrc;
    logic        jalr_sel;
    logic [31:0] ImmExt;
    logic [31:0] ALUResult;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        func7_5;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] instret;
    logic        misalign_err;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst_n(rst_n), .PCsrc(PCsrc), .jalr_sel(jalr_sel), .ImmExt(ImmExt),
        .ALUResult(ALUResult), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .op(op), .funct3(funct3), .func7_5(func7_5), .PC(PC), .PCPlus4(PCPlus4),
        .instret(instret), .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: "waiting" = a fetch is outstanding, "holding" = an instruction is live,
    // "dead" = misaligned redirect seen; "settle" = the one cycle after reset.
    bit          m_settle, m_waiting, m_holding, m_dead;
    logic [31:0] m_pc, m_instr, m_instret;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("imem_req", {31'd0, imem_req}, {31'd0, m_waiting});
        if (m_waiting) check_eq("imem_addr", imem_addr, m_pc);
        check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, m_holding});
        check_eq("PC", PC, m_pc);
        check_eq("PCPlus4", PCPlus4, m_pc + 32'd4);
        check_eq("instret", instret, m_instret);
        check_eq("misalign_err", {31'd0, misalign_err}, {31'd0, m_dead});
        if (m_holding || m_dead || m_settle) begin
            check_eq("instr", instr, m_instr);
            check_eq("op", {25'd0, op}, {25'd0, m_instr[6:0]});
            check_eq("funct3", {29'd0, funct3}, {29'd0, m_instr[14:12]});
            check_eq("func7_5", {31'd0, func7_5}, {31'd0, m_instr[30]});
        end
    endtask

    function automatic void model_reset();
        m_settle  = 1'b1;
        m_waiting = 1'b0;
        m_holding = 1'b0;
        m_dead    = 1'b0;
        m_pc      = RESET_PC;
        m_instr   = NOP_INSTR;
        m_instret = 32'd0;
    endfunction

    // One clock of the fetch/execute loop, stated as the architectural rules.
    function automatic void model_step(input bit rdy, input logic [31:0] rdata, input bit stl,
                                       input bit src, input bit jsel, input logic [31:0] imm,
                                       input logic [31:0] alu);
        logic [31:0] tgt;
        if (m_settle) begin
            m_settle  = 1'b0;
            m_waiting = 1'b1;
        end else if (m_waiting) begin
            if (rdy) begin
                m_instr   = rdata;
                m_waiting = 1'b0;
                m_holding = 1'b1;
            end
        end else if (m_holding && !stl) begin
            m_instret = m_instret + 32'd1;
            m_holding = 1'b0;
            if (!src)      tgt = m_pc + 32'd4;
            else if (jsel) tgt = {alu[31:1], 1'b0};
            else           tgt = m_pc + imm;
            if (tgt % 4 != 0) begin
                m_dead  = 1'b1;
                m_instr = NOP_INSTR;
            end else begin
                m_pc      = tgt;
                m_waiting = 1'b1;
            end
        end
    endfunction

    // Apply one cycle of inputs (caller is just past a falling edge), advance, check.
    task automatic cycle(input bit rdy, input logic [31:0] rdata, input bit stl, input bit src,
                         input bit jsel, input logic [31:0] imm, input logic [31:0] alu);
        imem_ready = rdy;
        imem_rdata = rdata;
        stall      = stl;
        PCsrc      = src;
        jalr_sel   = jsel;
        ImmExt     = imm;
        ALUResult  = alu;
        model_step(rdy, rdata, stl, src, jsel, imm, alu);
        @(negedge clk);
        check_all();
    endtask

    task automatic plain(input bit rdy);
        cycle(rdy, NOP_INSTR, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Asynchronous pulse between edges; outputs must show reset values before any clock edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_instr", instr, NOP_INSTR);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
    endtask

    logic [31:0] hold_pc, hold_instr, hold_cnt;

    initial begin
        rst_n = 1'b0; PCsrc = 1'b0; jalr_sel = 1'b0; ImmExt = '0; ALUResult = '0;
        stall = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Sequential fetch at 0,4,8 and three retirements.
        plain(1'b1); check_eq("t1_addr0", imem_addr, 32'h0);
        plain(1'b1); plain(1'b1); check_eq("t1_addr4", imem_addr, 32'h4);
        plain(1'b1); plain(1'b1); check_eq("t1_addr8", imem_addr, 32'h8);
        plain(1'b1); plain(1'b1); check_eq("t1_instret3", instret, 32'd3);

        // Backward branch from 0x10 by -8.
        plain(1'b1); plain(1'b1); plain(1'b1);
        check_eq("t2_pc10", PC, 32'h10);
        cycle(1'b1, NOP_INSTR, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'd0);
        check_eq("t2_addr8", imem_addr, 32'h8);

        // jalr clears bit 0 of the target.
        plain(1'b1);
        cycle(1'b1, NOP_INSTR, 1'b0, 1'b1, 1'b1, 32'd0, 32'h0000_0105);
        check_eq("t3_pc104", PC, 32'h104);
        check_eq("t3_noerr", {31'd0, misalign_err}, 32'd0);

        // Three imem wait cycles, then two stalled EXEC cycles.
        for (int i = 0; i < 3; i++) begin
            plain(1'b0);
            check_eq("t4_req_held", {31'd0, imem_req}, 32'd1);
            check_eq("t4_not_valid", {31'd0, instr_valid}, 32'd0);
        end
        cycle(1'b1, 32'h40A0_8093, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check_eq("t4_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("t4_funct7b", {31'd0, func7_5}, 32'd1);
        hold_pc = PC; hold_instr = instr; hold_cnt = instret;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 32'h4, 32'h3);
            check_eq("t4_stall_pc", PC, hold_pc);
            check_eq("t4_stall_instr", instr, hold_instr);
            check_eq("t4_stall_cnt", instret, hold_cnt);
        end
        plain(1'b1);

        // PC+4 wraps from the top of the address space with no error.
        plain(1'b1);
        cycle(1'b1, NOP_INSTR, 1'b0, 1'b1, 1'b1, 32'd0, 32'hFFFF_FFFC);
        plain(1'b1); plain(1'b1);
        check_eq("t7_wrap", PC, 32'h0);
        check_eq("t7_noerr", {31'd0, misalign_err}, 32'd0);

        // Misaligned branch from 0x20 is fatal until reset.
        plain(1'b1);
        cycle(1'b1, NOP_INSTR, 1'b0, 1'b1, 1'b1, 32'd0, 32'h20);
        plain(1'b1);
        check_eq("t5_pc20", PC, 32'h20);
        cycle(1'b1, NOP_INSTR, 1'b0, 1'b1, 1'b0, 32'h6, 32'd0);
        check_eq("t5_err", {31'd0, misalign_err}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            plain(1'b1);
            check_eq("t5_req_off", {31'd0, imem_req}, 32'd0);
            check_eq("t5_pc_kept", PC, 32'h20);
        end
        do_reset();
        check_eq("t5_err_clr", {31'd0, misalign_err}, 32'd0);

        // Reset dropped while a fetch is outstanding.
        plain(1'b1); plain(1'b1); plain(1'b1); plain(1'b0);
        do_reset();
        plain(1'b1);
        check_eq("t6_req", {31'd0, imem_req}, 32'd1);
        check_eq("t6_addr", imem_addr, RESET_PC);

        // Randomized traffic; recover from the fatal state with a reset.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] r, imm, alu;
            bit          rdy, stl, src, jsel;
            r    = $urandom;
            rdy  = ($urandom_range(0, 9) < 7);
            stl  = ($urandom_range(0, 9) < 3);
            src  = ($urandom_range(0, 9) < 4);
            jsel = $urandom_range(0, 1) != 0;
            imm  = {{20{r[11]}}, r[11:2], 2'b00};
            alu  = {$urandom, 2'b00} | 32'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) imm[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 39) == 0) alu[1]   = 1'b1;
            if ($urandom_range(0, 49) == 0) alu      = 32'hFFFF_FFFC;
            if (m_dead && $urandom_range(0, 4) == 0) do_reset();
            else cycle(rdy, $urandom, stl, src, jsel, imm, alu);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
